imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-007 SHALL have port in_inst, input, 32, raw RISC-V instruction.
REQ-008 SHALL have port in_tag, input, TAG_W, sideband tag.
REQ-009 SHALL have port flush, input, 1, discard all buffered entries.
REQ-010 SHALL have port out_valid, output, 1, decoded entry valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_imm, output, XLEN, sign- or zero-extended immediate.
REQ-013 SHALL have port out_fmt, output, 3, format code (imm_fmt_t).
REQ-014 SHALL have port out_illegal, output, 1, opcode not recognised.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the presented entry.

Function
REQ-016 SHALL decode by opcode inst[6:0]: OP 0110011 -> R, imm 0; OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J.
REQ-017 SHALL sign-extend the I/S/B/J immediates from inst[31] to XLEN; B and J bit 0 SHALL be 0.
REQ-018 SHALL build U immediate as {inst[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-019 SHALL, for OP-IMM with funct3 001 or 101, output zero-extended shamt: inst[24:20] for XLEN=32, inst[25:20] for XLEN=64 (funct7 bits excluded).
REQ-020 SHALL, for any other opcode, output imm 0, fmt ILL, out_illegal 1; illegal entries still flow through the handshake.
REQ-021 SHALL register the decode: an entry accepted at edge N is presented on out_valid after edge N (1-cycle latency) when the buffer is empty.
REQ-022 SHALL contain a 2-entry skid buffer (main + skid); in_ready = NOT skid_valid, driven from a flop only.
REQ-023 SHALL accept when in_valid AND in_ready; SHALL transfer out when out_valid AND out_ready; entries SHALL leave in arrival order.
REQ-024 SHALL, when main is full, out_ready low and an accept occurs, store the new entry in skid; on the next transfer skid moves to main.
REQ-025 SHALL, on simultaneous accept and transfer with skid empty, replace main with the new entry without a bubble.
REQ-026 SHALL hold out_imm/out_fmt/out_illegal/out_tag stable while out_valid AND NOT out_ready.
REQ-027 SHALL, on flush, clear both valid flags at the next edge; flush overrides a same-cycle accept (that entry is dropped).

Reset
REQ-028 SHALL, while rst_n low, force main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1; out_imm=0, out_fmt=R, out_illegal=0, out_tag=0.
REQ-029 SHALL discard any in-flight entries on reset assertion mid-operation; first accept is possible on the first edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with IMM_GEN_CSR_EN defined, decode SYSTEM 1110011 with funct3 101/110/111 as fmt Z, imm = zero-extended inst[19:15]; other SYSTEM funct3 -> fmt I.
REQ-031 SHALL, without IMM_GEN_CSR_EN, treat opcode 1110011 as illegal (REQ-020).

Structure
REQ-032 SHALL take opcode localparams and imm_fmt_t (R=0,I=1,S=2,B=3,U=4,J=5,Z=6,ILL=7) from shared package imm_pkg.
REQ-033 SHALL split combinational decode into sub-module imm_decode (inst -> imm, fmt, illegal), XLEN-parametrised; imm_gen_pipe holds the skid buffer.

Verification
REQ-034 SHALL check: 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, fmt I, one cycle after accept; 0x12345037 -> imm 0x12345000, fmt U.
REQ-035 SHALL check: 0x008000EF (jal +8) -> imm 8, fmt J; 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt B.
REQ-036 SHALL check: 0x4030D093 (srai 3) -> imm 3 (not 0x403); XLEN=64 0x03F09093 (slli 63) -> imm 63.
REQ-037 SHALL check: 0x3002D073 -> imm 5 fmt Z with IMM_GEN_CSR_EN; fmt ILL, illegal 1, imm 0 without.
REQ-038 SHALL check back-pressure: out_ready low, 3 accepts attempted -> 2 taken, in_ready 0; release -> tags emerge in order, no loss or duplicate.
REQ-039 SHALL check flush with both entries full plus same-cycle in_valid -> next cycle out_valid 0, in_ready 1, dropped entry never appears.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the RISC-V immediate generator: opcode constants,
// the immediate format code and small funct3 classification helpers.
package imm_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_t;

  // OP-IMM shifts (slli/srli/srai) carry a shift amount, not a signed immediate.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  // csrrwi/csrrsi/csrrci take a 5-bit unsigned immediate in the rs1 field.
  function automatic logic is_csri_f3(input logic [2:0] f3);
    return (f3 == 3'b101) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: raw instruction -> immediate, format, illegal.
// Optional feature macro: IMM_GEN_CSR_EN (decodes SYSTEM CSR-immediate forms).
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic signed [31:0] u_imm_s;
  logic [XLEN-1:0]   imm_s;
  imm_fmt_t          fmt_s;
  logic              illegal_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  // U-type value is sign-extended from bit 31 by the signed size cast below.
  assign u_imm_s  = {inst[31:12], 12'b0};

  // Opcode-driven immediate assembly; unknown opcodes yield ILL with a zero immediate.
  always_comb begin
    imm_s     = {XLEN{1'b0}};
    fmt_s     = FMT_R;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        imm_s = {XLEN{1'b0}};
        fmt_s = FMT_R;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt_s = FMT_I;
        if ((opcode_s == OPC_OP_IMM) && is_shift_f3(funct3_s)) begin
          // funct7 (e.g. the srai selector bit) must not leak into the shamt.
          if (XLEN == 32) begin
            imm_s = {{(XLEN-5){1'b0}}, inst[24:20]};
          end else begin
            imm_s = {{(XLEN-6){1'b0}}, inst[25:20]};
          end
        end else begin
          imm_s = {{(XLEN-12){inst[31]}}, inst[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_s = FMT_S;
        imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt_s = FMT_B;
        imm_s = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_s = FMT_U;
        imm_s = XLEN'(u_imm_s);
      end
      OPC_JAL: begin
        fmt_s = FMT_J;
        imm_s = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
`ifdef IMM_GEN_CSR_EN
      OPC_SYSTEM: begin
        if (is_csri_f3(funct3_s)) begin
          fmt_s = FMT_Z;
          imm_s = {{(XLEN-5){1'b0}}, inst[19:15]};
        end else begin
          fmt_s = FMT_I;
          imm_s = {{(XLEN-12){inst[31]}}, inst[31:20]};
        end
      end
`endif
      default: begin
        imm_s     = {XLEN{1'b0}};
        fmt_s     = FMT_ILL;
        illegal_s = 1'b1;
      end
    endcase
  end

  assign imm     = imm_s;
  assign fmt     = fmt_s;
  assign illegal = illegal_s;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (main + skid) ready/valid buffer.
// Decode happens on the input side so both buffer slots hold decoded entries.
// Optional feature macro: IMM_GEN_CSR_EN (passed through to imm_decode).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: {XLEN{1'b0}}, fmt: FMT_R, illegal: 1'b0,
                                   tag: {TAG_W{1'b0}}};

  logic [XLEN-1:0] dec_imm_s;
  logic [2:0]      dec_fmt_s;
  logic            dec_illegal_s;
  entry_t          new_entry_s;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept_s;
  logic   xfer_s;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm_s),
    .fmt     (dec_fmt_s),
    .illegal (dec_illegal_s)
  );

  assign new_entry_s = '{imm: dec_imm_s, fmt: dec_fmt_s, illegal: dec_illegal_s,
                         tag: in_tag};
  assign accept_s    = in_valid & in_ready_q;
  assign xfer_s      = main_valid_q & out_ready;

  // Buffer next-state: fill main first, spill to skid under back-pressure, flush wins.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept_s) begin
            main_d       = new_entry_s;
            main_valid_d = 1'b1;
          end else begin
            main_valid_d = 1'b0;
          end
        end
        2'b10: begin
          if (xfer_s && accept_s) begin
            // Back-to-back: new entry replaces the departing one, no bubble.
            main_d = new_entry_s;
          end else if (xfer_s) begin
            main_valid_d = 1'b0;
          end else if (accept_s) begin
            skid_d       = new_entry_s;
            skid_valid_d = 1'b1;
          end else begin
            main_d = main_q;
          end
        end
        2'b11: begin
          // Full: in_ready is low, so only a transfer can change state.
          if (xfer_s) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end else begin
            main_d = main_q;
          end
        end
        default: begin
          // Skid-only is unreachable; recover to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
    in_ready_d = ~skid_valid_d;
  end

  // Buffer state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= ENTRY_RST;
      skid_q       <= ENTRY_RST;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed decode cases, back-pressure,
// flush, mid-run reset and randomized traffic, against a queue-based model.
// Runs an XLEN=32 and an XLEN=64 instance side by side on the same stimulus.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int n_chk;
  int n_err;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } ent_t;
  ent_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .flush(flush), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_ill32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .flush(flush), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_ill64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint raw, input int bits);
    if (raw[bits-1]) return raw - (longint'(1) << bits);
    else return raw;
  endfunction

  // Reference decode straight from the instruction-set rules, in integer arithmetic.
  function automatic void ref_decode(input logic [31:0] inst, input bit x64,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint v;
    logic [2:0] f3;
    f3 = inst[14:12];
    v = 0; ill = 1'b0; fmt = 3'd0;
    case (inst[6:0])
      7'h33: fmt = 3'd0;
      7'h13, 7'h03, 7'h67: begin
        fmt = 3'd1;
        if (inst[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
          v = x64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
        else
          v = sx(longint'(inst[31:20]), 12);
      end
      7'h23: begin fmt = 3'd2; v = sx(longint'({inst[31:25], inst[11:7]}), 12); end
      7'h63: begin
        fmt = 3'd3;
        v = sx(longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
      end
      7'h37, 7'h17: begin fmt = 3'd4; v = sx(longint'({inst[31:12], 12'h000}), 32); end
      7'h6F: begin
        fmt = 3'd5;
        v = sx(longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
      end
`ifdef IMM_GEN_CSR_EN
      7'h73: begin
        if (f3 >= 3'd5) begin fmt = 3'd6; v = longint'(inst[19:15]); end
        else begin fmt = 3'd1; v = sx(longint'(inst[31:20]), 12); end
      end
`endif
      default: begin fmt = 3'd7; ill = 1'b1; v = 0; end
    endcase
    imm = x64 ? 64'(v) : {32'h0, v[31:0]};
  endfunction

  // Compare both instances against the model at the falling edge.
  task automatic sample();
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    @(negedge clk);
    check_val("out_valid32", out_valid32, q.size() > 0);
    check_val("in_ready32", in_ready32, q.size() < 2);
    check_val("out_valid64", out_valid64, q.size() > 0);
    check_val("in_ready64", in_ready64, q.size() < 2);
    if (q.size() > 0) begin
      ref_decode(q[0].inst, 1'b0, e_imm, e_fmt, e_ill);
      check_val("imm32", out_imm32, e_imm);
      check_val("fmt32", out_fmt32, e_fmt);
      check_val("ill32", out_ill32, e_ill);
      check_val("tag32", out_tag32, q[0].tag);
      ref_decode(q[0].inst, 1'b1, e_imm, e_fmt, e_ill);
      check_val("imm64", out_imm64, e_imm);
      check_val("fmt64", out_fmt64, e_fmt);
      check_val("ill64", out_ill64, e_ill);
      check_val("tag64", out_tag64, q[0].tag);
    end
  endtask

  // Apply inputs for the next rising edge and advance the FIFO model accordingly.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                       input logic rdy, input logic fl);
    ent_t e;
    bit acc, xf;
    in_valid = v; in_inst = inst; in_tag = tag; out_ready = rdy; flush = fl;
    acc = v && (q.size() < 2);
    xf  = (q.size() > 0) && rdy;
    e.inst = inst; e.tag = tag;
    if (fl) q.delete();
    else begin
      if (xf) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic dir_check(input logic [31:0] inst, input logic [31:0] e32,
                           input logic [63:0] e64, input logic [2:0] efmt, input logic eill);
    sample();
    drive(1'b1, inst, inst ^ 32'h5A5A_0000, 1'b1, 1'b0);
    sample();
    check_val("dir_imm32", out_imm32, e32);
    check_val("dir_imm64", out_imm64, e64);
    check_val("dir_fmt", out_fmt32, efmt);
    check_val("dir_ill", out_ill32, eill);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] rnd;
  logic [6:0]  opc_tab [12];

  initial begin
    n_chk = 0; n_err = 0;
    opc_tab = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73,
                7'h7F, 7'h0B};
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_tag = 32'h0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check_val("rst_out_valid", out_valid32, 1'b0);
    check_val("rst_in_ready", in_ready32, 1'b1);
    check_val("rst_imm", out_imm32, 32'h0);
    check_val("rst_fmt", out_fmt32, 3'd0);
    check_val("rst_ill", out_ill32, 1'b0);
    check_val("rst_tag", out_tag32, 32'h0);
    rst_n = 1'b1;

    // Directed decodes
    dir_check(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    dir_check(32'h12345037, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0);
    dir_check(32'h008000EF, 32'h00000008, 64'h8, 3'd5, 1'b0);
    dir_check(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0);
    dir_check(32'h4030D093, 32'h00000003, 64'h3, 3'd1, 1'b0);
    dir_check(32'h03F09093, 32'h0000001F, 64'h3F, 3'd1, 1'b0);
    dir_check(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0);
    dir_check(32'h00B50533, 32'h0, 64'h0, 3'd0, 1'b0);
`ifdef IMM_GEN_CSR_EN
    dir_check(32'h3002D073, 32'h5, 64'h5, 3'd6, 1'b0);
`else
    dir_check(32'h3002D073, 32'h0, 64'h0, 3'd7, 1'b1);
`endif

    // Back-pressure: three offered, two taken, released in order
    sample(); drive(1'b1, 32'h00100093, 32'd100, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00200093, 32'd101, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00300093, 32'd102, 1'b0, 1'b0);
    sample();
    check_val("bp_in_ready", in_ready32, 1'b0);
    check_val("bp_hold_tag", out_tag32, 32'd100);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    sample();
    check_val("bp_second_tag", out_tag32, 32'd101);
    check_val("bp_ready_back", in_ready32, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    sample();
    check_val("bp_drained", out_valid32, 1'b0);

    // Flush with both slots full and in_valid high
    drive(1'b1, 32'h00400093, 32'd200, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00500093, 32'd201, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00600093, 32'd202, 1'b0, 1'b1);
    sample();
    check_val("fl_out_valid", out_valid32, 1'b0);
    check_val("fl_in_ready", in_ready32, 1'b1);
    // Flush beats a same-cycle accept
    drive(1'b1, 32'h00700093, 32'd203, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00800093, 32'd204, 1'b1, 1'b1);
    sample();
    check_val("fl_drop_valid", out_valid32, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    sample();

    // Reset mid-operation, then accept on the first edge after release
    drive(1'b1, 32'h00900093, 32'd300, 1'b0, 1'b0);
    sample(); drive(1'b1, 32'h00A00093, 32'd301, 1'b0, 1'b0);
    #2 rst_n = 1'b0; in_valid = 1'b0;
    q.delete();
    #1;
    check_val("mr_out_valid", out_valid32, 1'b0);
    check_val("mr_in_ready", in_ready32, 1'b1);
    check_val("mr_imm", out_imm64, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h12345037, 32'd302, 1'b0, 1'b0);
    sample();
    check_val("mr_first_tag", out_tag32, 32'd302);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sample();
      rnd = $urandom();
      drive(($urandom_range(0, 9) < 7), {rnd[31:7], opc_tab[$urandom_range(0, 11)]},
            32'd1000 + 32'(i), ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
    end
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
